gate_sweep_sequencer: RTL and testbench
=======================================

# gate_sweep_sequencer

Self-checking stimulus controller for a 3-input combinational gate cell under characterization. On a start request it drives all eight input vectors to the gate in binary order. It waits a programmable settle time per vector, samples the gate output and compares it against a parameterised truth table. It reports a per-vector fail mask, an error count and a pass flag. It sits between the project's bench/top-level and any 3-input gate cell, replacing free-running `#delay` stimulus with a clocked, repeatable sweep.

## Interface
- `SETTLE_CYCLES`, default 2: cycles the vector is held before sampling `y`; legal range 1..15.
- `TRUTH`, default 8'hF7: expected output; bit i is the expected `y` for vector i = {a,b,c}. The default matches the inverted-a NAND3 cell, where only vector 3'b011 gives 0.

- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous reset, active-high.
- `start`  in  1: sweep request; sampled only in IDLE or DONE.
- `y`  in  1: gate output under test.
- `a`, `b`, `c`  out  1 each: registered gate inputs; {a,b,c} = current vector index.
- `busy`  out  1: high from start acceptance until the sweep ends.
- `done`  out  1: high in DONE state; holds until the next accepted start.
- `pass`  out  1: valid while `done`; 1 iff `err_count` == 0.
- `err_count`  out  4: number of mismatching vectors, 0..8.
- `fail_vec`  out  8: bit i set iff vector i mismatched.

## Operation
- States: IDLE, SETTLE, SAMPLE, DONE.
- Reset values: state IDLE; all outputs 0, including `a`, `b`, `c`, `busy`, `done`, `pass`, `err_count`, `fail_vec`. The vector counter and settle counter are 0.
- **IDLE or DONE with `start` = 1:**
  - vector ← 0, {a,b,c} ← 3'b000.
  - Clear `err_count`, `fail_vec`, `done` and `pass`; `busy` ← 1.
  - Settle counter ← `SETTLE_CYCLES`-1; go to SETTLE.
- **SETTLE:** decrement the settle counter each cycle. When it is 0, go to SAMPLE. Inputs are held stable throughout.
- **SAMPLE** (one cycle): compare `y` with `TRUTH`[vector].
  - On mismatch: set `fail_vec`[vector] and increment `err_count`.
  - If vector == 7: go to DONE, `busy` ← 0, `done` ← 1, `pass` ← (final count == 0).
  - Otherwise: vector ← vector+1, drive the new vector on {a,b,c}, reload the settle counter, go to SETTLE.
- **DONE:** `a`, `b`, `c` hold the last vector (3'b111). Results are frozen. A new `start` restarts the sweep.
- `start` while `busy` is ignored and has no effect on the sweep.
- `err_count` cannot overflow: at most 8 increments fit in 4 bits.
- An X or Z on `y` during SAMPLE is not specially handled; the bench must drive a clean value.

## Timing
- Start accepted at edge 0 means {a,b,c} = 0 is visible after edge 0.
- Each vector occupies `SETTLE_CYCLES`+1 cycles: `SETTLE_CYCLES` in SETTLE plus 1 in SAMPLE.
- `y` is sampled at the rising edge that ends the SAMPLE cycle.
- `done` rises after edge 8×(`SETTLE_CYCLES`+1), i.e. 24 cycles after acceptance with the defaults.
- The next vector appears on {a,b,c} at the same edge that samples the current one, so there are no idle cycles between vectors.
- `rst` asserted at any time, including mid-sweep, forces all outputs to their reset values immediately, without waiting for `clk`. Deassertion is synchronized by the environment. After reset the block waits in IDLE for a fresh `start`.

## Configuration
- Macro: `GSS_STOP_ON_FAIL_EN`.
- **Defined:** on the first mismatch in SAMPLE, record it (`fail_vec` bit, `err_count` = 1) and go straight to DONE with `pass` = 0. {a,b,c} hold the failing vector, so the bench can read the index directly from the pins.
- **Undefined (default):** always sweep all eight vectors and accumulate every mismatch.

## Test plan
- Correct cell model (y = !(!a&b&c)), defaults, one start pulse:
  - {a,b,c} steps 0..7, each held 3 cycles.
  - `done` at cycle 24 with `pass` = 1, `err_count` = 0, `fail_vec` = 8'h00.
- `y` tied 1, defaults: `done` at cycle 24 with `pass` = 0, `err_count` = 1, `fail_vec` = 8'h08.
- `y` tied 0, `SETTLE_CYCLES` = 1: `done` at cycle 16 with `err_count` = 7, `fail_vec` = 8'hF7.
- Extra `start` pulses at cycles 5 and 12 of a sweep: no restart, `done` still at cycle 24. A start in DONE clears the results and repeats an identical sweep.
- `rst` pulsed at cycle 10 mid-sweep: outputs go to 0 before the next `clk` edge, state IDLE, `busy` = 0. A subsequent start gives a full clean sweep.
- With `GSS_STOP_ON_FAIL_EN` and `y` tied 1: `done` at cycle 12, {a,b,c} = 3'b011, `err_count` = 1, `fail_vec` = 8'h08.

Source files
------------

// File: rtl/gate_sweep_sequencer.sv
// Clocked exhaustive sweep of a 3-input gate cell against a truth table.
// Optional GSS_STOP_ON_FAIL_EN: end the sweep at the first mismatching vector.
module gate_sweep_sequencer #(
    parameter int         SETTLE_CYCLES = 2,
    parameter logic [7:0] TRUTH         = 8'hF7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       y,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic [7:0] fail_vec
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETTLE = 2'd1;
    localparam logic [1:0] SAMPLE = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    localparam logic [3:0] RELOAD = 4'(SETTLE_CYCLES - 1);

    logic [1:0] state;
    logic [2:0] vec;
    logic [3:0] cnt;
    logic       mismatch;
    logic [3:0] err_next;
    logic       last;

    assign {a, b, c} = vec;
    assign mismatch  = (y != TRUTH[vec]);
    assign err_next  = err_count + {3'b000, mismatch};

`ifdef GSS_STOP_ON_FAIL_EN
    assign last = (vec == 3'd7) || mismatch;
`else
    assign last = (vec == 3'd7);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            vec       <= 3'd0;
            cnt       <= 4'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= 4'd0;
            fail_vec  <= 8'h00;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        vec       <= 3'd0;
                        err_count <= 4'd0;
                        fail_vec  <= 8'h00;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        busy      <= 1'b1;
                        cnt       <= RELOAD;
                        state     <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (cnt == 4'd0) state <= SAMPLE;
                    else             cnt   <= cnt - 4'd1;
                end
                SAMPLE: begin
                    if (mismatch) begin
                        fail_vec[vec] <= 1'b1;
                        err_count     <= err_next;
                    end
                    // Next vector launches on the same edge that samples this one.
                    if (last) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_next == 4'd0);
                        state <= DONE;
                    end else begin
                        vec   <= vec + 3'd1;
                        cnt   <= RELOAD;
                        state <= SETTLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gate_sweep_sequencer.sv
// Directed bench for gate_sweep_sequencer: vector table plus reset and restart sequences.
module tb_gate_sweep_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [1:0] start = 2'b00;
    int   mode [2];
    logic [1:0] y;
    logic [1:0] a, b, c, busy, done, pass;
    logic [3:0] err_count [2];
    logic [7:0] fail_vec [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // mode 0: healthy inverted-a NAND3, 1: tied high, 2: tied low
    for (genvar i = 0; i < 2; i++) begin : g_y
        assign y[i] = (mode[i] == 0) ? !(!a[i] & b[i] & c[i]) : (mode[i] == 1);
    end

    gate_sweep_sequencer #(.SETTLE_CYCLES(2), .TRUTH(8'hF7)) dut0 (
        .clk(clk), .rst(rst), .start(start[0]), .y(y[0]),
        .a(a[0]), .b(b[0]), .c(c[0]), .busy(busy[0]), .done(done[0]),
        .pass(pass[0]), .err_count(err_count[0]), .fail_vec(fail_vec[0])
    );

    gate_sweep_sequencer #(.SETTLE_CYCLES(1), .TRUTH(8'hF7)) dut1 (
        .clk(clk), .rst(rst), .start(start[1]), .y(y[1]),
        .a(a[1]), .b(b[1]), .c(c[1]), .busy(busy[1]), .done(done[1]),
        .pass(pass[1]), .err_count(err_count[1]), .fail_vec(fail_vec[1])
    );

    typedef struct {
        int         sel;
        int         mode;
        bit         extra;
        int         cyc;
        int         err;
        logic [7:0] fv;
        bit         pass;
        int         abc;
    } row_t;

    row_t rows [5];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic run_row(input int r);
        int s, per, k;
        s   = rows[r].sel;
        per = (s == 1) ? 2 : 3;
        mode[s] = rows[r].mode;
        @(negedge clk);
        start[s] = 1'b1;
        @(negedge clk);
        start[s] = 1'b0;
        k = 0;
        chk($sformatf("r%0d clr busy", r), int'(busy[s]), 1);
        chk($sformatf("r%0d clr done", r), int'(done[s]), 0);
        chk($sformatf("r%0d clr err", r), int'(err_count[s]), 0);
        chk($sformatf("r%0d clr fv", r), int'(fail_vec[s]), 0);
        while (!done[s] && k < 200) begin
            chk($sformatf("r%0d abc k%0d", r, k), int'({a[s], b[s], c[s]}), k / per);
            start[s] = rows[r].extra && (k == 4 || k == 11);
            @(negedge clk);
            k++;
        end
        start[s] = 1'b0;
        chk($sformatf("r%0d done cycle", r), k, rows[r].cyc);
        chk($sformatf("r%0d err_count", r), int'(err_count[s]), rows[r].err);
        chk($sformatf("r%0d fail_vec", r), int'(fail_vec[s]), int'(rows[r].fv));
        chk($sformatf("r%0d pass", r), int'(pass[s]), int'(rows[r].pass));
        chk($sformatf("r%0d busy end", r), int'(busy[s]), 0);
        chk($sformatf("r%0d abc end", r), int'({a[s], b[s], c[s]}), rows[r].abc);
    endtask

    initial begin
        mode[0] = 0;
        mode[1] = 0;
`ifdef GSS_STOP_ON_FAIL_EN
        rows[0] = '{0, 0, 1'b0, 24, 0, 8'h00, 1'b1, 7};
        rows[1] = '{0, 1, 1'b0, 12, 1, 8'h08, 1'b0, 3};
        rows[2] = '{0, 0, 1'b1, 24, 0, 8'h00, 1'b1, 7};
        rows[3] = '{1, 2, 1'b0,  2, 1, 8'h01, 1'b0, 0};
`else
        rows[0] = '{0, 0, 1'b0, 24, 0, 8'h00, 1'b1, 7};
        rows[1] = '{0, 1, 1'b0, 24, 1, 8'h08, 1'b0, 7};
        rows[2] = '{0, 0, 1'b1, 24, 0, 8'h00, 1'b1, 7};
        rows[3] = '{1, 2, 1'b0, 16, 7, 8'hF7, 1'b0, 7};
`endif
        rows[4] = '{0, 0, 1'b0, 24, 0, 8'h00, 1'b1, 7};

        #12;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst%0d abc", i), int'({a[i], b[i], c[i]}), 0);
            chk($sformatf("rst%0d busy", i), int'(busy[i]), 0);
            chk($sformatf("rst%0d done", i), int'(done[i]), 0);
            chk($sformatf("rst%0d pass", i), int'(pass[i]), 0);
            chk($sformatf("rst%0d err", i), int'(err_count[i]), 0);
            chk($sformatf("rst%0d fv", i), int'(fail_vec[i]), 0);
        end
        @(negedge clk);
        rst = 1'b0;

        for (int r = 0; r < 4; r++) run_row(r);

        // mid-sweep asynchronous reset on a failing sweep
        mode[0] = 2;
        @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (10) @(negedge clk);
`ifdef GSS_STOP_ON_FAIL_EN
        chk("pre-rst err", int'(err_count[0]), 1);
`else
        chk("pre-rst err", int'(err_count[0]), 3);
`endif
        #1 rst = 1'b1;
        #1;
        chk("mid-rst busy", int'(busy[0]), 0);
        chk("mid-rst done", int'(done[0]), 0);
        chk("mid-rst pass", int'(pass[0]), 0);
        chk("mid-rst abc", int'({a[0], b[0], c[0]}), 0);
        chk("mid-rst err", int'(err_count[0]), 0);
        chk("mid-rst fv", int'(fail_vec[0]), 0);
        #1 rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("idle busy", int'(busy[0]), 0);
        chk("idle done", int'(done[0]), 0);
        chk("idle abc", int'({a[0], b[0], c[0]}), 0);

        run_row(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
